rps_round_controller: RTL and testbench

Match controller on the player side of the stone-paper-scissors judge. It latches one move per player and drives the judge's move/start inputs with the required start handshake. It samples the judge's 8-bit result code in the single cycle it is valid, decodes it, and keeps per-player scores for a first-to-`WIN_TARGET` match.

---
 rtl/rps_round_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_rps_round_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_controller.sv
// rps_round_controller
//
// Player-side match controller for a stone-paper-scissors judge. Latches one
// move per player, drives the judge through a two-cycle start handshake,
// captures and decodes the judge's single-cycle result, and keeps scores for a
// first-to-WIN_TARGET match.
//
// Optional feature macro: RPS_PROTO_CHECK_EN
//   defined   - unknown judge codes set the sticky proto_err flag
//   undefined - proto_err is tied low; unknown codes score as invalid only
//
// Parameters:
//   WIN_TARGET     round wins needed to take the match (1..15)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   p1_sel/p2_sel  player moves (00 stone, 01 paper, 10 scissors, 11 passthrough)
//   p1_valid/p2_valid  one-cycle strobes latching the matching _sel
//   new_match      clear scores/flags and restart after a 2-cycle gap
//   judge_p1_move/judge_p2_move  moves presented to the judge
//   judge_start    judge start request, straight from a flop
//   judge_result   judge code: 0 tie, 50 P1, 100 P2, 200 invalid
//   round_done     one-cycle pulse when a round is scored
//   round_winner   00 tie, 01 P1, 10 P2, 11 invalid/unknown
//   p1_score/p2_score  rounds won
//   match_over     a player reached WIN_TARGET
//   match_winner   01 P1, 10 P2, 00 none
//   proto_err      sticky unknown-result-code flag

module rps_round_controller #(
  parameter int unsigned WIN_TARGET = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] p1_sel,
  input  logic       p1_valid,
  input  logic [1:0] p2_sel,
  input  logic       p2_valid,
  input  logic       new_match,
  output logic [1:0] judge_p1_move,
  output logic [1:0] judge_p2_move,
  output logic       judge_start,
  input  logic [7:0] judge_result,
  output logic       round_done,
  output logic [1:0] round_winner,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       proto_err
);

  localparam logic [3:0] Target = 4'(WIN_TARGET);

  localparam logic [7:0] CodeTie     = 8'd0;
  localparam logic [7:0] CodeP1      = 8'd50;
  localparam logic [7:0] CodeP2      = 8'd100;
  localparam logic [7:0] CodeInvalid = 8'd200;

  localparam logic [1:0] WinTie = 2'b00;
  localparam logic [1:0] WinP1  = 2'b01;
  localparam logic [1:0] WinP2  = 2'b10;
  localparam logic [1:0] WinBad = 2'b11;

  typedef enum logic [2:0] {
    StCollect,
    StStart,
    StSample,
    StRelease,
    StGap,
    StDone
  } state_e;

  state_e     state_q;
  logic [1:0] p1_move_q, p2_move_q;
  logic       p1_have_q, p2_have_q;
  logic       judge_start_q;
  logic       round_done_q;
  logic [1:0] round_winner_q;
  logic [3:0] p1_score_q, p2_score_q;
  logic       match_over_q;
  logic [1:0] match_winner_q;
  logic       gap_cnt_q;

  // Result decode, only consumed on the closing edge of SAMPLE.
  logic [1:0] code_winner;
  logic       p1_inc, p2_inc;
  logic [3:0] p1_score_nxt, p2_score_nxt;
`ifdef RPS_PROTO_CHECK_EN
  logic       code_unknown;
  logic       proto_err_q;
`endif

  always_comb begin
    code_winner = WinBad;
    p1_inc      = 1'b0;
    p2_inc      = 1'b0;
`ifdef RPS_PROTO_CHECK_EN
    code_unknown = 1'b0;
`endif
    case (judge_result)
      CodeTie:     code_winner = WinTie;
      CodeP1: begin
        code_winner = WinP1;
        p1_inc      = 1'b1;
      end
      CodeP2: begin
        code_winner = WinP2;
        p2_inc      = 1'b1;
      end
      CodeInvalid: code_winner = WinBad;
      default: begin
        code_winner = WinBad;
`ifdef RPS_PROTO_CHECK_EN
        code_unknown = 1'b1;
`endif
      end
    endcase
  end

  // Scores cannot overrun: the match ends the moment either hits Target.
  assign p1_score_nxt = p1_score_q + {3'b000, p1_inc};
  assign p2_score_nxt = p2_score_q + {3'b000, p2_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StCollect;
      p1_move_q      <= 2'b00;
      p2_move_q      <= 2'b00;
      p1_have_q      <= 1'b0;
      p2_have_q      <= 1'b0;
      judge_start_q  <= 1'b0;
      round_done_q   <= 1'b0;
      round_winner_q <= WinTie;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'b00;
      gap_cnt_q      <= 1'b0;
`ifdef RPS_PROTO_CHECK_EN
      proto_err_q    <= 1'b0;
`endif
    end else if (new_match) begin
      // Abort whatever is in flight; the round is dropped without scoring.
      state_q        <= StGap;
      p1_move_q      <= 2'b00;
      p2_move_q      <= 2'b00;
      p1_have_q      <= 1'b0;
      p2_have_q      <= 1'b0;
      judge_start_q  <= 1'b0;
      round_done_q   <= 1'b0;
      round_winner_q <= WinTie;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'b00;
      gap_cnt_q      <= 1'b0;
`ifdef RPS_PROTO_CHECK_EN
      proto_err_q    <= 1'b0;
`endif
    end else begin
      round_done_q <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (p1_have_q && p2_have_q) begin
            // Moves are frozen from here until the round is scored.
            state_q       <= StStart;
            judge_start_q <= 1'b1;
          end else begin
            if (p1_valid) begin
              p1_move_q <= p1_sel;
              p1_have_q <= 1'b1;
            end
            if (p2_valid) begin
              p2_move_q <= p2_sel;
              p2_have_q <= 1'b1;
            end
          end
        end
        StStart: begin
          state_q <= StSample;
        end
        StSample: begin
          // judge_result is only valid in this cycle.
          state_q        <= StRelease;
          judge_start_q  <= 1'b0;
          round_done_q   <= 1'b1;
          round_winner_q <= code_winner;
          p1_score_q     <= p1_score_nxt;
          p2_score_q     <= p2_score_nxt;
          p1_have_q      <= 1'b0;
          p2_have_q      <= 1'b0;
          if (p1_score_nxt == Target) begin
            match_over_q   <= 1'b1;
            match_winner_q <= WinP1;
          end else if (p2_score_nxt == Target) begin
            match_over_q   <= 1'b1;
            match_winner_q <= WinP2;
          end
`ifdef RPS_PROTO_CHECK_EN
          if (code_unknown) begin
            proto_err_q <= 1'b1;
          end
`endif
        end
        StRelease: begin
          state_q <= match_over_q ? StDone : StCollect;
        end
        StGap: begin
          // Two cycles of start low before the judge can be asked again.
          if (gap_cnt_q) begin
            state_q   <= StCollect;
            gap_cnt_q <= 1'b0;
          end else begin
            gap_cnt_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StCollect;
        end
      endcase
    end
  end

  assign judge_p1_move = p1_move_q;
  assign judge_p2_move = p2_move_q;
  assign judge_start   = judge_start_q;
  assign round_done    = round_done_q;
  assign round_winner  = round_winner_q;
  assign p1_score      = p1_score_q;
  assign p2_score      = p2_score_q;
  assign match_over    = match_over_q;
  assign match_winner  = match_winner_q;
`ifdef RPS_PROTO_CHECK_EN
  assign proto_err     = proto_err_q;
`else
  assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rps_round_controller.sv
// Directed bench for rps_round_controller with WIN_TARGET = 3. A small judge
// model returns the programmed code only in the second start-high cycle and
// a junk code otherwise, so a mistimed capture shows up as a wrong winner.

module tb_rps_round_controller;

`ifdef RPS_PROTO_CHECK_EN
  localparam bit ProtoEn = 1'b1;
`else
  localparam bit ProtoEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] p1_sel, p2_sel;
  logic       p1_valid, p2_valid;
  logic       new_match;
  logic [1:0] judge_p1_move, judge_p2_move;
  logic       judge_start;
  logic [7:0] judge_result;
  logic       round_done;
  logic [1:0] round_winner;
  logic [3:0] p1_score, p2_score;
  logic       match_over;
  logic [1:0] match_winner;
  logic       proto_err;

  always #5 clk = ~clk;

  rps_round_controller #(
    .WIN_TARGET(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p1_sel       (p1_sel),
    .p1_valid     (p1_valid),
    .p2_sel       (p2_sel),
    .p2_valid     (p2_valid),
    .new_match    (new_match),
    .judge_p1_move(judge_p1_move),
    .judge_p2_move(judge_p2_move),
    .judge_start  (judge_start),
    .judge_result (judge_result),
    .round_done   (round_done),
    .round_winner (round_winner),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .match_over   (match_over),
    .match_winner (match_winner),
    .proto_err    (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Judge model and handshake monitor.
  logic [7:0] judge_code = 8'd0;
  int hi_cnt = 0, lo_cnt = 0, last_hi = 0, last_lo = 0;
  int start_rises = 0, done_pulses = 0;

  assign judge_result = (judge_start && hi_cnt == 1) ? judge_code : 8'd123;

  always @(posedge clk) begin
    if (judge_start) begin
      hi_cnt <= hi_cnt + 1;
      lo_cnt <= 0;
      if (hi_cnt == 0) begin
        last_lo     <= lo_cnt;
        start_rises <= start_rises + 1;
      end
    end else begin
      lo_cnt <= lo_cnt + 1;
      hi_cnt <= 0;
      if (hi_cnt != 0) last_hi <= hi_cnt;
    end
    if (round_done) done_pulses <= done_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Both strobes in one cycle (V), then wait for round_done with a bound.
  task automatic play_round(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                            input logic [7:0] code, input logic [1:0] ew,
                            input int e1, input int e2, input logic emo,
                            input logic [1:0] emw, input logic epe);
    int n;
    judge_code = code;
    @(negedge clk);
    p1_sel = s1; p2_sel = s2; p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    check_eq({tag, ".p1move"}, judge_p1_move, s1);
    check_eq({tag, ".p2move"}, judge_p2_move, s2);
    n = 1;
    while (!round_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".latency"}, n, 4);
    check_eq({tag, ".winner"}, round_winner, ew);
    check_eq({tag, ".p1score"}, p1_score, e1);
    check_eq({tag, ".p2score"}, p2_score, e2);
    check_eq({tag, ".mover"}, match_over, emo);
    check_eq({tag, ".mwinner"}, match_winner, emw);
    check_eq({tag, ".proto"}, proto_err, epe);
    @(negedge clk);
    check_eq({tag, ".donepulse"}, round_done, 0);
    check_eq({tag, ".starthigh"}, last_hi, 2);
  endtask

  // Pulse new_match for one cycle; returns in the first GAP cycle.
  task automatic restart(input string tag);
    @(negedge clk);
    new_match = 1'b1;
    @(negedge clk);
    new_match = 1'b0;
    check_eq({tag, ".start"}, judge_start, 0);
    check_eq({tag, ".p1score"}, p1_score, 0);
    check_eq({tag, ".p2score"}, p2_score, 0);
    check_eq({tag, ".winner"}, round_winner, 0);
    check_eq({tag, ".mover"}, match_over, 0);
    check_eq({tag, ".mwinner"}, match_winner, 0);
    check_eq({tag, ".proto"}, proto_err, 0);
  endtask

  initial begin
    int rises0, dones0;
    rst_n = 1'b0; new_match = 1'b0;
    p1_sel = 2'b00; p2_sel = 2'b00; p1_valid = 1'b0; p2_valid = 1'b0;

    // Reset
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst.start", judge_start, 0);
    check_eq("rst.done", round_done, 0);
    check_eq("rst.winner", round_winner, 0);
    check_eq("rst.p1score", p1_score, 0);
    check_eq("rst.p2score", p2_score, 0);
    check_eq("rst.mover", match_over, 0);
    check_eq("rst.mwinner", match_winner, 0);
    check_eq("rst.proto", proto_err, 0);
    check_eq("rst.p1move", judge_p1_move, 0);
    check_eq("rst.p2move", judge_p2_move, 0);
    rises0 = start_rises;
    tick(5);
    check_eq("idle.start", judge_start, 0);
    check_eq("idle.rises", start_rises, rises0);

    // Tie, invalid, P1 win
    play_round("tie", 2'b01, 2'b01, 8'd0, 2'b00, 0, 0, 1'b0, 2'b00, 1'b0);
    play_round("inv", 2'b00, 2'b01, 8'd200, 2'b11, 0, 0, 1'b0, 2'b00, 1'b0);
    play_round("p1win", 2'b00, 2'b10, 8'd50, 2'b01, 1, 0, 1'b0, 2'b00, 1'b0);

    // Repeated P1 strobe: last one wins; P2 strobe comes later (cycle V)
    judge_code = 8'd100;
    @(negedge clk); p1_sel = 2'b01; p1_valid = 1'b1;
    @(negedge clk); p1_sel = 2'b10;
    @(negedge clk); p1_valid = 1'b0; p2_sel = 2'b00; p2_valid = 1'b1;
    @(negedge clk); p2_valid = 1'b0;
    tick(3);
    check_eq("last.done", round_done, 1);
    check_eq("last.p1move", judge_p1_move, 2'b10);
    check_eq("last.winner", round_winner, 2'b10);
    check_eq("last.p2score", p2_score, 1);

    // Restart; strobes held through both GAP cycles must be ignored
    restart("nm1");
    rises0 = start_rises;
    p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    tick(6);
    check_eq("gap.ignored", start_rises, rises0);

    // P2 takes the match 3-0
    play_round("p2r1", 2'b10, 2'b00, 8'd100, 2'b10, 0, 1, 1'b0, 2'b00, 1'b0);
    play_round("p2r2", 2'b01, 2'b10, 8'd100, 2'b10, 0, 2, 1'b0, 2'b00, 1'b0);
    play_round("p2r3", 2'b00, 2'b01, 8'd100, 2'b10, 0, 3, 1'b1, 2'b10, 1'b0);

    // DONE ignores strobes
    rises0 = start_rises;
    @(negedge clk); p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk); p1_valid = 1'b0; p2_valid = 1'b0;
    tick(8);
    check_eq("done.rises", start_rises, rises0);
    check_eq("done.p2score", p2_score, 3);
    check_eq("done.mover", match_over, 1);

    // Restart; first COLLECT cycle is two GAP cycles after new_match
    restart("nm2");
    @(negedge clk);
    play_round("unk", 2'b11, 2'b00, 8'd77, 2'b11, 0, 0, 1'b0, 2'b00, ProtoEn);
    play_round("sticky", 2'b00, 2'b00, 8'd0, 2'b00, 0, 0, 1'b0, 2'b00, ProtoEn);
    restart("nm3");

    // Abort in SAMPLE: no round_done, no scoring
    tick(2);
    judge_code = 8'd50;
    dones0 = done_pulses;
    @(negedge clk); p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk); p1_valid = 1'b0; p2_valid = 1'b0;
    tick(2);
    check_eq("abort.insample", judge_start, 1);
    new_match = 1'b1;
    @(negedge clk);
    new_match = 1'b0;
    check_eq("abort.startlow", judge_start, 0);
    tick(6);
    check_eq("abort.nodone", done_pulses, dones0);
    check_eq("abort.p1score", p1_score, 0);
    play_round("post", 2'b01, 2'b00, 8'd50, 2'b01, 1, 0, 1'b0, 2'b00, 1'b0);
    check_eq("abort.lowgap", (last_lo >= 2) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
